// File: rtl/univ_shift_reg_pkg.sv
// Shared encodings for the universal shift register: operating modes and burst FSM states.
package univ_shift_reg_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned ST_W   = 2;

  localparam logic [MODE_W-1:0] MODE_HOLD  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD  = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL   = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHR   = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROL   = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROR   = 3'd5;
  localparam logic [MODE_W-1:0] MODE_ASR   = 3'd6;
  localparam logic [MODE_W-1:0] MODE_BURST = 3'd7;

  // Each active state owns one bit, so busy/done are direct flop outputs.
  localparam logic [ST_W-1:0] ST_IDLE  = 2'b00;
  localparam logic [ST_W-1:0] ST_SHIFT = 2'b01;
  localparam logic [ST_W-1:0] ST_DONE  = 2'b10;

endpackage : univ_shift_reg_pkg

// File: rtl/univ_shift_reg_dffe_rst_bit.sv
// Single storage bit with clock enable and asynchronous active-high reset to a per-instance value.
module dffe_rst_bit
  import univ_shift_reg_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : dffe_rst_bit

// File: rtl/univ_shift_reg.sv
// WIDTH-bit register bank with load, shift/rotate modes and a self-timed LSB-first serial burst.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("univ_shift_reg: WIDTH must be in 2..32");
  end

  logic [WIDTH-1:0] q_d;
  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Storage bank: one enabled flop per bit, each with its own reset value.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dffe_rst_bit #(
      .RESET_VAL (RESET_VAL[i])
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (q_d[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath mux; mode only matters in IDLE.
  always_comb begin
    q_d     = q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        case (mode)
          MODE_HOLD:  q_d = q;
          MODE_LOAD:  q_d = d;
          MODE_SHL:   q_d = {q[WIDTH-2:0], sin};
          MODE_SHR:   q_d = {sin, q[WIDTH-1:1]};
          MODE_ROL:   q_d = {q[WIDTH-2:0], q[WIDTH-1]};
          MODE_ROR:   q_d = {q[0], q[WIDTH-1:1]};
          MODE_ASR:   q_d = {q[WIDTH-1], q[WIDTH-1:1]};
          MODE_BURST: begin
            q_d     = d;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
          default:    q_d = q;
        endcase
      end
      ST_SHIFT: begin
        q_d   = {1'b0, q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];
  assign busy     = state_q[0];
  assign done     = state_q[1];

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=8, RESET_VAL=0.
module tb_univ_shift_reg;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin;
  logic [W-1:0] q;
  logic         sout_msb;
  logic         sout_lsb;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(
    .WIDTH     (W),
    .RESET_VAL (8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin      (sin),
    .q        (q),
    .sout_msb (sout_msb),
    .sout_lsb (sout_lsb),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    en = 1'b1; mode = 3'd1; d = v;
    step();
  endtask

  initial begin
    logic [W-1:0] burst_val;
    int           seq [10];
    int           busy_cycles;

    burst_val = 8'h96;
    seq = '{0, 1, 2, 2, 2, 3, 4, 5, 6, 7};

    rst = 1'b1; en = 1'b0; mode = 3'd0; d = '0; sin = 1'b0;
    step(); step();
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    load(8'hA5);
    chk("load_a5", 32'(q), 32'hA5);
    chk("sout_msb_a5", 32'(sout_msb), 32'd1);
    chk("sout_lsb_a5", 32'(sout_lsb), 32'd1);

    // Asynchronous reset pulse between edges
    #2 rst = 1'b1;
    #1 chk("async_rst_q", 32'(q), 32'h00);
    rst = 1'b0;
    load(8'hA5);
    chk("reload_a5", 32'(q), 32'hA5);

    mode = 3'd2; sin = 1'b1; step();
    chk("shl", 32'(q), 32'h4B);
    load(8'hA5);
    mode = 3'd3; sin = 1'b0; step();
    chk("shr", 32'(q), 32'h52);
    load(8'hA5);
    mode = 3'd5; step();
    chk("ror", 32'(q), 32'hD2);
    load(8'hA5);
    mode = 3'd4; step();
    chk("rol", 32'(q), 32'h4B);
    load(8'h85);
    mode = 3'd6; step();
    chk("asr", 32'(q), 32'hC2);
    mode = 3'd0; step();
    chk("hold", 32'(q), 32'hC2);

    // Clock enable low freezes everything
    load(8'h3C);
    en = 1'b0; mode = 3'd1; d = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_hold_q", 32'(q), 32'h3C);
      chk("en_hold_busy", 32'(busy), 32'd0);
      chk("en_hold_done", 32'(done), 32'd0);
    end

    // Full burst, mode/d churned while busy
    en = 1'b1; mode = 3'd7; d = burst_val;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("burst_busy", 32'(busy), 32'd1);
      chk("burst_done", 32'(done), 32'd0);
      chk("burst_bit", 32'(sout_lsb), 32'(burst_val[i]));
      mode = (i % 2 == 0) ? 3'd1 : 3'd4;
      d = 8'hFF;
      step();
    end
    chk("burst_end_done", 32'(done), 32'd1);
    chk("burst_end_busy", 32'(busy), 32'd0);
    chk("burst_end_q", 32'(q), 32'h00);
    mode = 3'd1; d = 8'hFF;
    step();
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_q", 32'(q), 32'h00);

    // Burst with a two-cycle stall after the third bit
    mode = 3'd7; d = burst_val;
    step();
    mode = 3'd0;
    busy_cycles = 0;
    for (int k = 0; k < 10; k++) begin
      if (busy) busy_cycles++;
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_bit", 32'(sout_lsb), 32'(burst_val[seq[k]]));
      en = !(k == 2 || k == 3);
      step();
    end
    chk("stall_busy_cycles", 32'(busy_cycles), 32'd10);
    chk("stall_done", 32'(done), 32'd1);
    en = 1'b1;
    step();
    chk("stall_idle", 32'(done), 32'd0);

    // Reset in the middle of a burst
    mode = 3'd7; d = burst_val;
    step();
    mode = 3'd0;
    step(); step();
    chk("mid_bit3", 32'(sout_lsb), 32'(burst_val[2]));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_q", 32'(q), 32'h00);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    load(8'h5A);
    chk("post_rst_load", 32'(q), 32'h5A);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_univ_shift_reg
